// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared timer width and FSM state encoding.
// Ports: none (package).
package tick_timer_pkg;
    localparam int TT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10
    } state_t;
endpackage

// File: rtl/tick_timer_if.sv
// tick_timer_if: control/status bundle between a timer controller and tick_timer.
// Ports: tick, start, stop, auto, period, ack (controller -> timer);
//        count, busy, done, expired, ovr (timer -> controller).
interface tick_timer_if import tick_timer_pkg::*; #(parameter int WIDTH = TT_WIDTH);
    logic             tick;
    logic             start;
    logic             stop;
    logic             auto;
    logic [WIDTH-1:0] period;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             expired;
    logic             ovr;
    modport master (output tick, start, stop, auto, period, ack,
                    input  count, busy, done, expired, ovr);
    modport slave  (input  tick, start, stop, auto, period, ack,
                    output count, busy, done, expired, ovr);
endinterface

// File: rtl/tick_timer.sv
// tick_timer: down-counts prescaler ticks, pulses done on expiry, keeps sticky expired/overrun flags.
// Ports: CLK clock; RES async active-low reset; bus (slave) carries tick/start/stop/auto/period/ack
//        in and count/busy/done/expired/ovr out, all outputs registered.
module tick_timer import tick_timer_pkg::*; #(
    parameter int WIDTH = TT_WIDTH
) (
    input  logic        CLK,
    input  logic        RES,
    tick_timer_if.slave bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n, per_q, per_n;
    logic             auto_q, auto_n, busy, busy_n, done, done_n;
    logic             expired, exp_n, ovr, ovr_n, fire;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state   <= IDLE;
            count   <= '0;
            per_q   <= '0;
            auto_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            per_q   <= per_n;
            auto_q  <= auto_n;
            busy    <= busy_n;
            done    <= done_n;
            expired <= exp_n;
            ovr     <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        per_n   = per_q;
        auto_n  = auto_q;
        fire    = 1'b0;
        case (state)
            IDLE: if (bus.start && bus.period != '0) begin
                per_n   = bus.period;
                auto_n  = bus.auto;
                count_n = bus.period;
                state_n = RUN;
            end
            // stop outranks a coinciding final tick, so an abort never reports expiry
            RUN: if (bus.stop) begin
                count_n = '0;
                state_n = IDLE;
            end else if (bus.tick) begin
                if (count > WIDTH'(1)) begin
                    count_n = count - WIDTH'(1);
                end else if (count == WIDTH'(1)) begin
                    fire    = 1'b1;
                    count_n = auto_q ? per_q : '0;
                    state_n = auto_q ? RUN : WAIT;
                end
            end
            WAIT: if (bus.ack || bus.stop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = state_n == RUN;
        done_n = fire;
        // an expiry beats a same-cycle ack; overrun only when the previous expiry was not acked
        exp_n  = fire | (expired & ~bus.ack);
        ovr_n  = fire ? (ovr | (expired & ~bus.ack)) : (ovr & ~bus.ack);
    end

    assign bus.count   = count;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.expired = expired;
    assign bus.ovr     = ovr;
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: scoreboard bench for tick_timer with a divide-by-8 tick source and manual ticks.
// Ports: none (top-level bench).
module tb_tick_timer;
    localparam int W = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2;

    typedef struct {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        logic         expired;
        logic         ovr;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    bit   res_next = 1'b0;
    tick_timer_if #(.WIDTH(W)) bus();
    tick_timer #(.WIDTH(W)) dut (.CLK(clk), .RES(res), .bus(bus));

    always #5 clk = ~clk;

    exp_t  q[$];
    int    vectors = 0, miscompares = 0;
    int    pre = 0;
    bit    use_pre = 1'b1;
    string phase = "init";

    int m_mode = M_IDLE, m_cnt = 0, m_per = 0;
    bit m_auto = 0, m_exp = 0, m_ovr = 0, m_done = 0;

    function automatic exp_t snap();
        exp_t e;
        e.count   = m_cnt[W-1:0];
        e.busy    = m_mode == M_RUN;
        e.done    = m_done;
        e.expired = m_exp;
        e.ovr     = m_ovr;
        return e;
    endfunction

    task automatic check(input exp_t e, input string tag);
        vectors++;
        if (bus.count !== e.count || bus.busy !== e.busy || bus.done !== e.done ||
            bus.expired !== e.expired || bus.ovr !== e.ovr) begin
            miscompares++;
            $display("FAIL %s/%s t=%0t: got count=%0d busy=%0b done=%0b expired=%0b ovr=%0b, expected count=%0d busy=%0b done=%0b expired=%0b ovr=%0b",
                     phase, tag, $time, bus.count, bus.busy, bus.done, bus.expired, bus.ovr,
                     e.count, e.busy, e.done, e.expired, e.ovr);
        end
    endtask

    task automatic model_clear();
        m_mode = M_IDLE; m_cnt = 0; m_per = 0;
        m_auto = 0; m_exp = 0; m_ovr = 0; m_done = 0;
    endtask

    // Reference: ticks remaining to expiry, reloaded from the captured period in auto mode.
    task automatic model_step(input bit s, input bit p, input bit a, input bit t, input int pd, input bit au);
        m_done = 0;
        if (!res) begin
            model_clear();
            return;
        end
        if (m_mode == M_RUN) begin
            if (p) begin
                m_cnt = 0;
                m_mode = M_IDLE;
            end else if (t) begin
                if (m_cnt == 1) begin
                    m_done = 1;
                    m_cnt = m_auto ? m_per : 0;
                    if (!m_auto) m_mode = M_WAIT;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else if (m_mode == M_IDLE) begin
            if (s && pd != 0) begin
                m_per = pd; m_auto = au; m_cnt = pd; m_mode = M_RUN;
            end
        end else if (a || p) begin
            m_mode = M_IDLE;
        end
        if (m_done) begin
            if (m_exp && !a) m_ovr = 1;
            m_exp = 1;
        end else if (a) begin
            m_exp = 0;
            m_ovr = 0;
        end
    endtask

    task automatic cyc(input bit s, input bit p, input bit a, input int pd, input bit au, input bit mt);
        exp_t z;
        @(negedge clk);
        if (res && !res_next) begin
            res = 1'b0;
            #1;
            z = '{default: 0};
            check(z, "async_reset");
        end
        res = res_next;
        pre = (pre + 1) % 8;
        bus.tick   = use_pre ? (pre == 0) : mt;
        bus.start  = s;
        bus.stop   = p;
        bus.ack    = a;
        bus.period = pd[W-1:0];
        bus.auto   = au;
        model_step(s, p, a, bus.tick, pd, au);
        q.push_back(snap());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check(q.pop_front(), "scoreboard");
        end
    end

    initial begin
        bus.tick = 0; bus.start = 0; bus.stop = 0; bus.ack = 0; bus.period = '0; bus.auto = 0;
        phase = "reset";
        idle(3);
        res_next = 1'b1;
        idle(3);

        phase = "reset_mid_run";
        use_pre = 1;
        cyc(1, 0, 0, 5, 0, 0);
        for (int i = 0; i < 100 && m_cnt != 3; i++) idle(1);
        res_next = 1'b0;
        idle(2);
        res_next = 1'b1;
        idle(30);

        phase = "one_shot";
        cyc(1, 0, 0, 3, 0, 0);
        idle(40);
        cyc(0, 0, 1, 0, 0, 0);
        idle(3);

        phase = "auto_overrun";
        cyc(1, 0, 0, 2, 1, 0);
        idle(40);
        cyc(0, 0, 1, 0, 0, 0);
        idle(20);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        phase = "stop_vs_tick";
        use_pre = 0;
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        idle(3);

        phase = "period_zero";
        cyc(1, 0, 0, 0, 0, 0);
        idle(3);

        phase = "start_in_run";
        use_pre = 1;
        cyc(1, 0, 0, 4, 0, 0);
        idle(5);
        cyc(1, 0, 0, 9, 1, 0);
        idle(40);
        cyc(0, 0, 1, 0, 0, 0);

        phase = "period_255";
        cyc(1, 0, 0, 255, 0, 0);
        idle(255 * 8 + 10);
        cyc(0, 0, 1, 0, 0, 0);

        phase = "ack_collision";
        use_pre = 0;
        cyc(1, 0, 0, 2, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (i % 500 == 0) use_pre = $urandom_range(0, 1) == 0;
            res_next = $urandom_range(0, 599) != 0;
            r = $urandom_range(0, 15);
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                r == 0 ? 0 : (r == 1 ? 255 : $urandom_range(1, 6)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        res_next = 1'b1;
        idle(2);

        @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
